mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its surroundings.
// It holds the CPU request/response channel, the read-only video fetch
// channel and the single-port synchronous RAM port.
//   slave  : the arbiter's view (requests and RAM read data in; responses and RAM controls out)
//   master : the requester/RAM side (the opposite directions)
interface mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic [7:0]  cpu_in;
  logic        cpu_ready;

  logic        vid_req;
  logic [15:0] vid_address;
  logic [7:0]  vid_data;
  logic        vid_ready;

  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_address, cpu_out,
    input  vid_req, vid_address,
    input  mem_rdata,
    output cpu_in, cpu_ready, vid_data, vid_ready,
    output mem_address, mem_wdata, mem_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_address, cpu_out,
    output vid_req, vid_address,
    output mem_rdata,
    input  cpu_in, cpu_ready, vid_data, vid_ready,
    input  mem_address, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for one single-port synchronous RAM.
// A CPU (read/write) and a video fetcher (read-only) share the RAM; one
// access is in flight at a time. Video wins a simultaneous request unless it
// has already been granted VID_BURST_MAX times in a row while the CPU waited.
// Ports:
//   clock   : system clock, rising-edge active
//   reset_n : asynchronous active-low reset, clears all state and outputs
//   bus     : mem_arbiter_if.slave (CPU channel, video channel, RAM port)
// Access timing, counted from the edge that samples the request in IDLE:
//   read  : ACCESS, RD_LATCH, DONE (ready in the 3rd cycle)
//   write : ACCESS, DONE           (ready in the 2nd cycle)
module mem_arbiter #(
  parameter int unsigned VID_BURST_MAX = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_LATCH, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_VID} owner_t;

  localparam logic [3:0] BURST_MAX = 4'(VID_BURST_MAX);

  state_t     state;
  owner_t     owner;
  logic [3:0] streak;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= BURST_MAX) ? BURST_MAX : v + 4'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      owner           <= OWN_VID;
      streak          <= 4'd0;
      bus.cpu_ready   <= 1'b0;
      bus.vid_ready   <= 1'b0;
      bus.cpu_in      <= 8'h00;
      bus.vid_data    <= 8'h00;
      bus.mem_address <= 16'h0000;
      bus.mem_wdata   <= 8'h00;
      bus.mem_we      <= 1'b0;
    end else begin
      case (state)
        // Requests are only looked at here; the grant edge also drives the RAM.
        IDLE: begin
          if (bus.vid_req && !(bus.cpu_req && streak == BURST_MAX)) begin
            owner           <= OWN_VID;
            bus.mem_address <= bus.vid_address;
            state           <= ACCESS;
            // The streak only measures how long the CPU has been kept waiting.
            streak          <= bus.cpu_req ? sat_inc(streak) : 4'd0;
          end else if (bus.cpu_req) begin
            owner           <= OWN_CPU;
            bus.mem_address <= bus.cpu_address;
            streak          <= 4'd0;
            state           <= ACCESS;
            if (bus.cpu_we) begin
              bus.mem_wdata <= bus.cpu_out;
              bus.mem_we    <= 1'b1;
            end
          end else begin
            streak <= 4'd0;
          end
        end

        // RAM samples mem_address at the end of this cycle. mem_we being
        // high here is exactly the "CPU write" case, so it selects the path.
        ACCESS: begin
          bus.mem_we <= 1'b0;
          if (bus.mem_we) begin
            bus.cpu_ready <= 1'b1;
            state         <= DONE;
          end else begin
            state <= RD_LATCH;
          end
        end

        // mem_rdata is valid now; capture it for the owner and raise ready.
        RD_LATCH: begin
          if (owner == OWN_CPU) begin
            bus.cpu_in    <= bus.mem_rdata;
            bus.cpu_ready <= 1'b1;
          end else begin
            bus.vid_data  <= bus.mem_rdata;
            bus.vid_ready <= 1'b1;
          end
          state <= DONE;
        end

        DONE: begin
          bus.cpu_ready <= 1'b0;
          bus.vid_ready <= 1'b0;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
